// File: rtl/layer_sequencer.sv
// Layer program sequencer: walks PC over [first..last], hands each layer to the MAC engine
// via layer_start/layer_done, and gates host writes to the instruction memory while a run is active.
module layer_sequencer #(
  parameter int INSTRUCTION_MEMORY_SIZE   = 32,
  parameter int INSTRUCTION_MEMORY_FIELDS = 24,
  parameter int INSTRUCTION_MEMORY_WIDTH  = 16,
  parameter int BIT_WIDTH_EXTERNAL_PORT   = 32,
  parameter int EOP_FIELD                 = 0,
  parameter int EOP_BIT                   = 15,
  parameter int TIMEOUT_CYCLES            = 65535
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [BIT_WIDTH_EXTERNAL_PORT-1:0]  first_layer,
  input  logic [BIT_WIDTH_EXTERNAL_PORT-1:0]  last_layer,
  input  logic                                abort,
  input  logic [INSTRUCTION_MEMORY_FIELDS-1:0][INSTRUCTION_MEMORY_WIDTH-1:0] instruction,
  input  logic                                layer_done,
  output logic [BIT_WIDTH_EXTERNAL_PORT-1:0]  PC,
  output logic                                layer_start,
  output logic                                busy,
  output logic                                done,
  output logic                                error,
  output logic [1:0]                          err_code,
  output logic [15:0]                         layers_done_cnt,
  input  logic                                wr_en_ext_in,
  input  logic [BIT_WIDTH_EXTERNAL_PORT-1:0]  wr_addr_ext_in,
  input  logic [BIT_WIDTH_EXTERNAL_PORT-1:0]  wr_data_ext_in,
  output logic                                wr_en_ext_im,
  output logic [BIT_WIDTH_EXTERNAL_PORT-1:0]  wr_addr_ext_im,
  output logic [BIT_WIDTH_EXTERNAL_PORT-1:0]  wr_data_ext_im,
  output logic                                wr_reject
);

  localparam int BW = BIT_WIDTH_EXTERNAL_PORT;
  localparam logic [BW-1:0] SIZE_W  = BW'(INSTRUCTION_MEMORY_SIZE);
  localparam logic [31:0]   TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, RUN, NEXT, DONE} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   pc_q, last_q;
  logic [15:0]     cnt_q;
  logic [31:0]     wdog_q;
  logic            eop_q, error_q, wr_reject_q;
  logic [1:0]      err_code_q;
  logic            range_ok, timeout, last_hit, kill;

  assign range_ok = (first_layer <= last_layer) && (last_layer < SIZE_W);
  assign timeout  = (TIMEOUT_CYCLES != 0) && (wdog_q == TO_LAST);
  assign last_hit = (pc_q == last_q) || eop_q;
  // abort outranks every other event once a run is under way
  assign kill     = abort && (state_q != IDLE);

  // only the EOP flag of the current layer matters to the sequencer
  logic unused_instruction;
  assign unused_instruction = ^instruction;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (kill) state_d = IDLE;
    else begin
      case (state_q)
        IDLE:    if (start && range_ok) state_d = FETCH;
        FETCH:   state_d = ISSUE;
        ISSUE:   state_d = RUN;
        RUN:     if (layer_done) state_d = NEXT;
                 else if (timeout) state_d = IDLE;
        NEXT:    state_d = last_hit ? DONE : FETCH;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy         = (state_q != IDLE);
    layer_start  = (state_q == ISSUE) && !abort;
    done         = (state_q == DONE) && !abort;
    wr_en_ext_im = wr_en_ext_in && (state_q == IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q        <= '0;
      last_q      <= '0;
      cnt_q       <= '0;
      wdog_q      <= '0;
      eop_q       <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= 2'd0;
      wr_reject_q <= 1'b0;
    end else begin
      error_q     <= 1'b0;
      wr_reject_q <= wr_en_ext_in && (state_q != IDLE);
      if (kill) begin
        error_q    <= 1'b1;
        err_code_q <= 2'd3;
      end else begin
        case (state_q)
          IDLE: if (start) begin
            if (!range_ok) begin
              error_q    <= 1'b1;
              err_code_q <= 2'd1;
            end else begin
              last_q     <= last_layer;
              pc_q       <= first_layer;
              cnt_q      <= '0;
              err_code_q <= 2'd0;
            end
          end
          ISSUE: begin
            eop_q  <= instruction[EOP_FIELD][EOP_BIT];
            wdog_q <= '0;
          end
          RUN: begin
            if (layer_done) begin
              if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
            end else if (timeout) begin
              error_q    <= 1'b1;
              err_code_q <= 2'd2;
            end else begin
              wdog_q <= wdog_q + 32'd1;
            end
          end
          NEXT: if (!last_hit) pc_q <= pc_q + 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign PC              = pc_q;
  assign error           = error_q;
  assign err_code        = err_code_q;
  assign layers_done_cnt = cnt_q;
  assign wr_reject       = wr_reject_q;
  assign wr_addr_ext_im  = wr_addr_ext_in;
  assign wr_data_ext_im  = wr_data_ext_in;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: behavioural instruction memory plus a hand-driven engine.
module tb_layer_sequencer;
  localparam int SIZE = 32, FIELDS = 24, W = 16, TO = 10;

  logic clk = 1'b0, reset = 1'b0;
  logic start = 1'b0, abort = 1'b0, layer_done = 1'b0;
  logic [31:0] first_layer = '0, last_layer = '0;
  logic [FIELDS-1:0][W-1:0] instruction;
  logic [31:0] PC;
  logic layer_start, busy, done, error;
  logic [1:0] err_code;
  logic [15:0] layers_done_cnt;
  logic wr_en_ext_in = 1'b0;
  logic [31:0] wr_addr_ext_in = '0, wr_data_ext_in = '0;
  logic wr_en_ext_im, wr_reject;
  logic [31:0] wr_addr_ext_im, wr_data_ext_im;

  layer_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .first_layer(first_layer),
    .last_layer(last_layer), .abort(abort), .instruction(instruction),
    .layer_done(layer_done), .PC(PC), .layer_start(layer_start), .busy(busy),
    .done(done), .error(error), .err_code(err_code), .layers_done_cnt(layers_done_cnt),
    .wr_en_ext_in(wr_en_ext_in), .wr_addr_ext_in(wr_addr_ext_in),
    .wr_data_ext_in(wr_data_ext_in), .wr_en_ext_im(wr_en_ext_im),
    .wr_addr_ext_im(wr_addr_ext_im), .wr_data_ext_im(wr_data_ext_im),
    .wr_reject(wr_reject));

  always #5 clk = ~clk;

  // instruction memory: synchronous read of the whole layer addressed by PC
  logic [W-1:0] mem [SIZE*FIELDS] = '{default: '0};
  always @(posedge clk) begin
    if (wr_en_ext_im) mem[int'(wr_addr_ext_im)] <= wr_data_ext_im[W-1:0];
    for (int f = 0; f < FIELDS; f++) instruction[f] <= mem[int'(PC[4:0])*FIELDS + f];
  end

  int ls_seen = 0, done_seen = 0;
  always @(negedge clk) begin
    if (layer_start) ls_seen++;
    if (done) done_seen++;
  end

  int total = 0, bad = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ls(output int ok);
    ok = 0;
    for (int k = 0; k < 40; k++) begin
      if (layer_start) begin ok = 1; return; end
      @(negedge clk);
    end
  endtask

  task automatic wait_done(output int ok);
    ok = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) begin ok = 1; return; end
      @(negedge clk);
    end
  endtask

  task automatic host_wr(input int addr, input logic [31:0] data);
    wr_en_ext_in = 1'b1; wr_addr_ext_in = 32'(addr); wr_data_ext_in = data;
    #1 chk("wr_pass_en", 32'(wr_en_ext_im), 1);
    chk("wr_pass_addr", wr_addr_ext_im, 32'(addr));
    @(negedge clk);
    wr_en_ext_in = 1'b0;
  endtask

  // full run with an engine answering each layer one cycle after it enters RUN
  task automatic run_seq(input string tag, input logic [31:0] f, input logic [31:0] l, input int nexp);
    int ok, ls0;
    ls0 = ls_seen;
    start = 1'b1; first_layer = f; last_layer = l;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < nexp; i++) begin
      wait_ls(ok);
      chk({tag, "_ls_seen"}, 32'(ok), 1);
      chk({tag, "_ls_pc"}, PC, f + 32'(i));
      @(negedge clk); layer_done = 1'b1;
      @(negedge clk); layer_done = 1'b0;
    end
    wait_done(ok);
    chk({tag, "_done"}, 32'(ok), 1);
    chk({tag, "_cnt"}, 32'(layers_done_cnt), 32'(nexp));
    chk({tag, "_final_pc"}, PC, f + 32'(nexp - 1));
    chk({tag, "_ls_total"}, 32'(ls_seen - ls0), 32'(nexp));
    @(negedge clk);
    chk({tag, "_idle"}, 32'(busy), 0);
  endtask

  initial begin
    int ok, n, d0;
    @(negedge clk); @(negedge clk);
    chk("rst_pc", PC, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pulses", {29'd0, layer_start, done, error}, 0);
    chk("rst_errcode", 32'(err_code), 0);
    chk("rst_cnt", 32'(layers_done_cnt), 0);
    reset = 1'b1;
    @(negedge clk);

    // 1: program three layers while idle, then run them
    for (int i = 0; i < 3; i++) host_wr(i*FIELDS + 1, 32'hA000 + 32'(i));
    chk("wr_no_reject", 32'(wr_reject), 0);
    chk("mem_l2", 32'(mem[2*FIELDS+1]), 32'hA002);
    run_seq("t1", 0, 2, 3);

    // 2: end-of-program flag in layer 5 cuts the 4..9 run after two layers
    host_wr(5*FIELDS + 0, 32'h8000);
    run_seq("t2", 4, 9, 2);

    // 3: bad ranges are rejected without leaving IDLE
    start = 1'b1; first_layer = 7; last_layer = 3;
    @(negedge clk); start = 1'b0;
    chk("t3a_err", 32'(error), 1);
    chk("t3a_code", 32'(err_code), 1);
    chk("t3a_busy", 32'(busy), 0);
    @(negedge clk);
    chk("t3a_pulse_end", 32'(error), 0);
    chk("t3a_code_hold", 32'(err_code), 1);
    start = 1'b1; first_layer = 0; last_layer = 32;
    @(negedge clk); start = 1'b0;
    chk("t3b_err", 32'(error), 1);
    chk("t3b_code", 32'(err_code), 1);
    chk("t3b_busy", 32'(busy), 0);

    // 4: host write during RUN is dropped; single-layer run
    start = 1'b1; first_layer = 1; last_layer = 1;
    @(negedge clk); start = 1'b0;
    chk("t4_code_clr", 32'(err_code), 0);
    wait_ls(ok);
    chk("t4_ls", 32'(ok), 1);
    @(negedge clk);
    wr_en_ext_in = 1'b1; wr_addr_ext_in = 32'(FIELDS + 1); wr_data_ext_in = 32'hDEAD;
    #1 chk("t4_wr_blocked", 32'(wr_en_ext_im), 0);
    @(negedge clk);
    wr_en_ext_in = 1'b0;
    chk("t4_reject", 32'(wr_reject), 1);
    chk("t4_mem_kept", 32'(mem[FIELDS+1]), 32'hA001);
    layer_done = 1'b1; @(negedge clk); layer_done = 1'b0;
    wait_done(ok);
    chk("t4_done", 32'(ok), 1);
    chk("t4_cnt", 32'(layers_done_cnt), 1);
    @(negedge clk);
    chk("t4_reject_end", 32'(wr_reject), 0);

    // 5: watchdog fires after TO cycles in RUN, then an abort in a new run
    start = 1'b1; first_layer = 0; last_layer = 1;
    @(negedge clk); start = 1'b0;
    wait_ls(ok);
    n = 0;
    for (int k = 0; k < TO; k++) begin
      @(negedge clk);
      if (busy && !error) n++;
    end
    chk("t5_run_cycles", 32'(n), TO);
    @(negedge clk);
    chk("t5_to_err", 32'(error), 1);
    chk("t5_to_code", 32'(err_code), 2);
    chk("t5_to_idle", 32'(busy), 0);
    d0 = done_seen;
    start = 1'b1; first_layer = 0; last_layer = 3;
    @(negedge clk); start = 1'b0;
    chk("t5_code_clr", 32'(err_code), 0);
    wait_ls(ok);
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("t5_ab_err", 32'(error), 1);
    chk("t5_ab_code", 32'(err_code), 3);
    chk("t5_ab_idle", 32'(busy), 0);
    repeat (5) @(negedge clk);
    chk("t5_ab_nodone", 32'(done_seen - d0), 0);

    // 6: layer_done -> next layer_start latency, then reset mid-run
    start = 1'b1; first_layer = 3; last_layer = 4;
    @(negedge clk); start = 1'b0;
    wait_ls(ok);
    @(negedge clk); layer_done = 1'b1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); layer_done = 1'b0; n++;
      if (layer_start) break;
    end
    chk("t6_latency", 32'(n), 3);
    chk("t6_pc", PC, 4);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("t6_rst_pc", PC, 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_cnt", 32'(layers_done_cnt), 0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    chk("t6_rst_pulses", {30'd0, done, error}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
